// File: rtl/dmem_pkg.sv
// Shared widths and FSM state encoding for the data-memory responder.
package dmem_pkg;

   localparam int DMEM_DATA_W = 32;
   localparam int DMEM_BE_W   = 4;
   localparam int WAIT_CNT_W  = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } dmem_state_e;

endpackage

// File: rtl/dmem_if.sv
// Request/response valid-ready channel between the core load/store path and the responder.
interface dmem_if;
   import dmem_pkg::*;

   logic                   req_valid;
   logic                   req_ready;
   logic                   req_we;
   logic [31:0]            req_addr;
   logic [DMEM_DATA_W-1:0] req_wdata;
   logic [DMEM_BE_W-1:0]   req_be;
   logic                   resp_valid;
   logic                   resp_ready;
   logic [DMEM_DATA_W-1:0] resp_rdata;
   logic                   resp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );

endinterface

// File: rtl/dmem_array.sv
// Word storage with per-byte-lane write enables and a registered read port; contents are not reset.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int  DEPTH_WORDS = 1024,
   localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
   input  logic                   clk,
   input  logic                   we,
   input  logic                   re,
   input  logic [DMEM_BE_W-1:0]   be,
   input  logic [IDX_W-1:0]       idx,
   input  logic [DMEM_DATA_W-1:0] wdata,
   output logic [DMEM_DATA_W-1:0] rdata
);

   logic [DMEM_DATA_W-1:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < DMEM_BE_W; i++) begin
            if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
      if (re) rdata <= mem[idx];
   end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with programmable wait states.
// Optional access checking (misaligned / out-of-window) is enabled by defining DMEM_ERR_EN.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | req_ready high; a valid request is latched and the timer loaded
//   BUSY  | wait-state timer counting down; access commits when it hits 0
//   RESP  | resp_valid high; data/err held until the initiator takes them
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int          DEPTH_WORDS = 1024,
   parameter int          WAIT_STATES = 2,
   parameter logic [31:0] BASE_ADDR   = 32'h0
) (
   input  logic   clk,
   input  logic   rst,
   dmem_if.slave  bus
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);

   logic [1:0]             state;
   logic [WAIT_CNT_W-1:0]  cnt;
   logic                   we_q;
   logic                   err_q;
   logic [DMEM_BE_W-1:0]   be_q;
   logic [DMEM_DATA_W-1:0] wdata_q;
   logic [IDX_W-1:0]       idx_q;
   logic [DMEM_DATA_W-1:0] arr_rdata;
   logic [31:0]            offset;
   logic                   acc_err;
   logic                   commit;

   assign offset = bus.req_addr - BASE_ADDR;
   assign commit = (state == BUSY) && (cnt == '0);

`ifdef DMEM_ERR_EN
   assign acc_err = (offset[1:0] != 2'b00) || (offset[31:IDX_W+2] != '0);
`else
   logic unused_addr_bits;
   assign acc_err          = 1'b0;
   assign unused_addr_bits = ^{offset[1:0], offset[31:IDX_W+2]};
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         be_q    <= '0;
         wdata_q <= '0;
         idx_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  we_q    <= bus.req_we;
                  err_q   <= acc_err;
                  be_q    <= bus.req_be;
                  wdata_q <= bus.req_wdata;
                  idx_q   <= offset[IDX_W+1:2];
                  cnt     <= WAIT_CNT_W'(WAIT_STATES);
                  state   <= BUSY;
               end
            end
            BUSY: begin
               if (cnt == '0) state <= RESP;
               else           cnt   <= cnt - 1'b1;
            end
            RESP: begin
               if (bus.resp_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // The array's read register only updates on a load commit, so it holds through RESP.
   dmem_array #(
      .DEPTH_WORDS (DEPTH_WORDS)
   ) u_array (
      .clk   (clk),
      .we    (commit && we_q && !err_q),
      .re    (commit && !we_q && !err_q),
      .be    (be_q),
      .idx   (idx_q),
      .wdata (wdata_q),
      .rdata (arr_rdata)
   );

   assign bus.req_ready  = (state == IDLE);
   assign bus.resp_valid = (state == RESP);
   assign bus.resp_rdata = (bus.resp_valid && !we_q && !err_q) ? arr_rdata : '0;
   assign bus.resp_err   = bus.resp_valid && err_q;

endmodule
